// File: rtl/accum_mem_ctrl_pkg.sv
// accum_mem_ctrl_pkg: shared FSM encoding and parameter sanity helper
package accum_mem_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  function automatic bit addr_width_ok(input int aw, input int rows);
    return aw >= $clog2(rows);
  endfunction
endpackage

// File: rtl/accum_col_lane.sv
// accum_col_lane: per-column row counter, finish flag, one-stage write pipe and add/bypass mux
module accum_col_lane #(
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_zero,
  input  logic                  i_run,
  input  logic                  i_mode,
  input  logic [ADDR_WIDTH-1:0] i_last,
  input  logic                  i_valid,
  input  logic [ACC_WIDTH-1:0]  i_data,
  input  logic [ACC_WIDTH-1:0]  i_rd_data,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [ACC_WIDTH-1:0]  o_wr_data,
  output logic                  o_fin_nxt,
  output logic                  o_drop
);
  logic [ADDR_WIDTH-1:0] r_cnt, r_pa;
  logic [ACC_WIDTH-1:0]  r_pd;
  logic                  r_fin, r_pv;
  logic                  w_acc, w_hit;
  assign w_acc     = i_run && i_valid && !r_fin;
  assign w_hit     = r_cnt == i_last;
  assign o_rd_en   = w_acc && i_mode;
  assign o_rd_addr = o_rd_en ? r_cnt : '0;
  assign o_wr_en   = r_pv;
  assign o_wr_addr = r_pv ? r_pa : '0;
  assign o_wr_data = !r_pv ? '0 : i_mode ? i_rd_data + r_pd : r_pd;
  assign o_fin_nxt = r_fin || (w_acc && w_hit);
  assign o_drop    = i_valid && (!i_run || r_fin);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_fin <= 1'b0;
      r_pv  <= 1'b0;
      r_pa  <= '0;
      r_pd  <= '0;
    end else begin
      r_pv <= w_acc;
      if (w_acc) begin
        r_pa <= r_cnt;
        r_pd <= i_data;
      end
      if (i_clear) begin
        r_cnt <= '0;
        r_fin <= i_zero;
      end else if (w_acc) begin
        r_cnt <= r_cnt + 1'b1;
        r_fin <= w_hit;
      end
    end
  end
endmodule

// File: rtl/accum_mem_ctrl.sv
// accum_mem_ctrl: de-skews systolic column results into accumulator banks, overwriting or accumulating per pass
module accum_mem_ctrl
  import accum_mem_ctrl_pkg::*;
#(
  parameter int SYS_COL    = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int DATA_WIDTH = 16,
  parameter int ACCUM_ROW  = 128,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [DATA_WIDTH-1:0]           num_row,
  input  logic                            accum_mode,
  input  logic [SYS_COL-1:0]              in_valid,
  input  logic [SYS_COL*ACC_WIDTH-1:0]    in_data,
  output logic [SYS_COL-1:0]              mem_rd_en,
  output logic [SYS_COL*ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [SYS_COL*ACC_WIDTH-1:0]    mem_rd_data,
  output logic [SYS_COL-1:0]              mem_wr_en,
  output logic [SYS_COL*ADDR_WIDTH-1:0]   mem_wr_addr,
  output logic [SYS_COL*ACC_WIDTH-1:0]    mem_wr_data,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);
  localparam logic [DATA_WIDTH:0] ROWS = (DATA_WIDTH+1)'(ACCUM_ROW);
  state_t                r_state, w_next;
  logic                  r_mode, r_err;
  logic [ADDR_WIDTH-1:0] r_last;
  logic [SYS_COL-1:0]    w_fin_nxt, w_drop;
  logic [DATA_WIDTH:0]   w_eff;
  logic                  w_accept, w_zero, w_run;
  if (!addr_width_ok(ADDR_WIDTH, ACCUM_ROW)) begin : g_bad_width
    $error("ADDR_WIDTH too small for ACCUM_ROW");
  end
  assign w_accept = start && r_state == S_IDLE;
  assign w_zero   = num_row == '0;
  assign w_eff    = {1'b0, num_row} > ROWS ? ROWS : {1'b0, num_row};
  assign w_run    = r_state == S_RUN;
  assign busy     = r_state == S_RUN || r_state == S_DRAIN;
  assign done     = r_state == S_DONE;
  assign err      = r_err;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == S_IDLE)  ? (w_accept ? (w_zero ? S_DONE : S_RUN) : S_IDLE) :
             (r_state == S_RUN)   ? (&w_fin_nxt ? S_DRAIN : S_RUN) :
             (r_state == S_DRAIN) ? S_DONE : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_last  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= !w_accept && (r_err || |w_drop);
      if (w_accept) begin
        r_mode <= accum_mode;
        r_last <= ADDR_WIDTH'(w_eff - 1'b1);
      end
    end
  end
  for (genvar c = 0; c < SYS_COL; c++) begin : g_lane
    accum_col_lane #(.ACC_WIDTH(ACC_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_accept),
      .i_zero    (w_zero),
      .i_run     (w_run),
      .i_mode    (r_mode),
      .i_last    (r_last),
      .i_valid   (in_valid[c]),
      .i_data    (in_data[c*ACC_WIDTH +: ACC_WIDTH]),
      .i_rd_data (mem_rd_data[c*ACC_WIDTH +: ACC_WIDTH]),
      .o_rd_en   (mem_rd_en[c]),
      .o_rd_addr (mem_rd_addr[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .o_wr_en   (mem_wr_en[c]),
      .o_wr_addr (mem_wr_addr[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .o_wr_data (mem_wr_data[c*ACC_WIDTH +: ACC_WIDTH]),
      .o_fin_nxt (w_fin_nxt[c]),
      .o_drop    (w_drop[c])
    );
  end
endmodule
